rr_mux6_arb: RTL and testbench
==============================

# rr_mux6_arb

Round-robin arbiter and sequencer for the six-input one-hot multiplexer datapath. Six requesters each present a K-bit word and a request. The block grants one requester at a time and drives the one-hot select for an internal 6:1 one-hot mux. It forwards the selected word to a single downstream consumer over a valid/ready handshake. It sits between the requester bank and the shared output resource, and it bounds each owner's tenure with a burst limit so that access stays fair.

## Interface
- K, 4, data width of every requester word and of out_data
- MAXBURST, 4, maximum transfers per grant tenure; legal range 1..15
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset; synchronous and active-high
- req  input  6  per-requester request; bit i belongs to requester i
- d0..d5  input  K each  requester data words; di belongs to requester i
- out_ready  input  1  downstream accepts out_data this cycle
- gnt  output  6  registered one-hot grant, which is also the mux select; all zeros means no owner
- ack  output  6  combinational one-hot pulse; bit i is high in the cycle requester i's word is consumed
- out_valid  output  1  out_data holds a valid word
- out_data  output  K  the one-hot mux of d0..d5 selected by gnt; 0 when gnt is all zeros

## Operation
- State machine states: IDLE, GRANT.
- Registered state:
  - state
  - gnt (6 bits, one-hot or zero)
  - ptr (0..5), the index of the highest-priority requester
  - cnt (0..MAXBURST-1), transfers in the current tenure
- IDLE:
  - gnt = 0.
  - If req is nonzero, select the first set bit scanning ptr, ptr+1, … modulo 6.
  - Load gnt with that one-hot value, clear cnt, and go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT:
  - Owner o is the index of the set bit in gnt.
  - out_valid = req[o].
  - Transfer = out_valid & out_ready; ack[o] = transfer; all other ack bits are 0.
- Release condition, evaluated each GRANT cycle:
  - req[o] == 0, or
  - a transfer occurs with cnt == MAXBURST-1.
- On release:
  - next state = IDLE, gnt ← 0, ptr ← (o+1) mod 6, cnt ← 0.
- Otherwise:
  - stay in GRANT.
  - cnt ← cnt+1 on a transfer, and is held otherwise.
- out_data = OR over i of (gnt[i] ? di : 0). It is purely combinational from the gnt register. The mux never sees a multi-hot select.
- Requests from non-owners are ignored during GRANT; they are serviced in later tenures in ptr order.
- A requester may change di at any time. The consumer samples out_data only in transfer cycles.

## Timing
- Reset: on the clk edge with rst=1:
  - state=IDLE, gnt=0, ptr=0, cnt=0.
  - Consequently out_valid=0, ack=0, out_data=0 in the following cycle.
  - rst overrides every other input.
  - Reset during GRANT drops the grant at that edge with no ack afterwards.
  - A transfer occurring in the same cycle as rst=1 is still acked combinationally in that cycle; its grant is lost.
- Grant latency:
  - Request visible at edge n (state IDLE): gnt is set after edge n.
  - out_valid is high in cycle n+1 if req is still high.
- Hand-off:
  - Release at edge m gives IDLE in cycle m+1, gnt=0, out_valid=0.
  - The next grant is visible after edge m+1.
  - This imposes exactly one idle bubble between tenures.
- Throughput: with out_ready held high, the owner moves one word per cycle, up to MAXBURST words per tenure.
- Backpressure: while out_ready=0, the owner keeps the grant. cnt is frozen and there is no timeout.
- MAXBURST=1: every transfer releases the grant.
- Wrap-around: ptr after owner 5 becomes 0.
- All requests simultaneous: the pointer rotates so that grant order is 0,1,2,3,4,5,0,… when all req stay high.

## Test plan
- Reset: hold rst for 2 cycles with req=6'b111111 -> gnt=0, out_valid=0, out_data=0, ack=0 throughout and one cycle after rst falls. Then the first gnt is 6'b000001.
- Single requester: d0..d5=1..6, req=6'b000100, out_ready=1, MAXBURST=4 -> gnt=6'b000100 one cycle after req, out_data=3. ack[2] pulses 4 consecutive cycles, followed by one cycle with gnt=0, followed by a regrant to 2.
- Round-robin fairness: req=6'b111111 held, out_ready=1 -> tenures of 4 transfers each. out_data sequence is 1,2,3,4,5,6,1 with one bubble between tenures, and ptr wraps 5→0.
- Early release: owner 3 drops req after 2 transfers -> out_valid falls the same cycle, gnt=0 next cycle. The next grant goes to the lowest set req at index ≥4, wrapping.
- Backpressure: owner 1 granted, out_ready=0 for 5 cycles -> gnt stays 6'b000010, out_data=2, ack=0, cnt unchanged. Once ready returns, 4 transfers complete before release.
- Mid-tenure reset: assert rst after 2 transfers by owner 4 -> next cycle gnt=0, ptr=0. A subsequent req=6'b110001 grants requester 0 first.

Source files
------------

// File: rtl/rr_mux6_arb.sv
// rr_mux6_arb: round-robin arbiter for six requesters feeding a one-hot 6:1 mux.
// A grant tenure lasts until the owner drops its request or completes
// MAXBURST transfers; the pointer then moves past the owner so access rotates.
module rr_mux6_arb #(
  parameter int K        = 4,
  parameter int MAXBURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   req,
  input  logic [K-1:0] d0,
  input  logic [K-1:0] d1,
  input  logic [K-1:0] d2,
  input  logic [K-1:0] d3,
  input  logic [K-1:0] d4,
  input  logic [K-1:0] d5,
  input  logic         out_ready,
  output logic [5:0]   gnt,
  output logic [5:0]   ack,
  output logic         out_valid,
  output logic [K-1:0] out_data
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q;
  logic [5:0] gnt_q;
  logic [2:0] ptr_q;
  logic [3:0] cnt_q;

  logic [5:0] gnt_d;
  logic [2:0] ptr_d;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic [2:0] owner_idx;
  logic       owner_req;
  logic       transfer;
  logic       last_beat;
  logic       release_now;

  logic [K-1:0] d_arr  [6];
  logic [K-1:0] masked [6];

  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;
  assign d_arr[4] = d4;
  assign d_arr[5] = d5;

  // Priority scan starting at ptr, wrapping modulo 6; first requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int k = 0; k < 6; k++) begin
      cand = 3'(({1'b0, ptr_q} + 4'(k)) % 4'd6);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    gnt_d = 6'b000001 << pick_idx;
  end

  // Encode the current owner index from the one-hot grant.
  always_comb begin
    owner_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (gnt_q[i]) owner_idx = 3'(i);
    end
    ptr_d = (owner_idx == 3'd5) ? 3'd0 : owner_idx + 3'd1;
  end

  // Handshake and tenure-release decisions for the current owner.
  always_comb begin
    owner_req   = (state_q == GRANT) && ((req & gnt_q) != 6'b0);
    transfer    = owner_req && out_ready;
    last_beat   = (cnt_q == 4'(MAXBURST - 1));
    release_now = !owner_req || (transfer && last_beat);
  end

  assign gnt       = gnt_q;
  assign out_valid = owner_req;
  assign ack       = transfer ? gnt_q : 6'b0;

  // Each lane is gated by its own grant bit; the OR forms the one-hot mux.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_lane
      assign masked[gi] = {K{gnt_q[gi]}} & d_arr[gi];
    end
  endgenerate

  // Combine the gated lanes; zero when nobody owns the mux.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 6; i++) begin
      out_data = out_data | masked[i];
    end
  end

  // Arbiter FSM: grant selection, burst counting and pointer rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 6'b0;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= 6'b0;
          if (pick_found) begin
            gnt_q   <= gnt_d;
            cnt_q   <= 4'd0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_q <= IDLE;
            gnt_q   <= 6'b0;
            ptr_q   <= ptr_d;
            cnt_q   <= 4'd0;
          end else if (transfer) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 6'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux6_arb.sv
// Directed testbench for rr_mux6_arb: one task per scenario, inline checks.
module tb_rr_mux6_arb;

  logic       clk;
  logic       rst;
  logic [5:0] req;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic       out_ready;
  logic [5:0] gnt, ack, gnt1, ack1;
  logic       out_valid, out_valid1;
  logic [3:0] out_data, out_data1;

  int tests;
  int fails;

  rr_mux6_arb #(.K(4), .MAXBURST(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .out_ready(out_ready), .gnt(gnt), .ack(ack),
    .out_valid(out_valid), .out_data(out_data)
  );

  rr_mux6_arb #(.K(4), .MAXBURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .out_ready(out_ready), .gnt(gnt1), .ack(ack1),
    .out_valid(out_valid1), .out_data(out_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 6'b0;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 6'b111111;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) step();
      if (c == 2) rst = 1'b0;
      #1;
      tests++;
      if (gnt !== 6'b0 || out_valid !== 1'b0 || out_data !== 4'd0 || ack !== 6'b0) begin
        fails++;
        $display("FAIL reset_idle c=%0d: gnt=%b ov=%b data=%0d ack=%b, required 0/0/0/0", c, gnt, out_valid, out_data, ack);
      end
    end
    step();
    tests++;
    if (gnt !== 6'b000001 || out_data !== 4'd1) begin
      fails++;
      $display("FAIL reset_first_grant: gnt=%b data=%0d, required 000001/1", gnt, out_data);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req = 6'b000100;
    step();
    tests++;
    if (gnt !== 6'b000100 || out_data !== 4'd3) begin
      fails++;
      $display("FAIL single_grant: gnt=%b data=%0d, required 000100/3", gnt, out_data);
    end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (ack !== 6'b000100) begin
        fails++;
        $display("FAIL single_ack beat=%0d: ack=%b, required 000100", j, ack);
      end
      step();
    end
    tests++;
    if (gnt !== 6'b0 || ack !== 6'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_bubble: gnt=%b ack=%b ov=%b, required 0/0/0", gnt, ack, out_valid);
    end
    step();
    tests++;
    if (gnt !== 6'b000100) begin
      fails++;
      $display("FAIL single_regrant: gnt=%b, required 000100", gnt);
    end
    $display("[TB] test_single done");
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_g;
    do_reset();
    req = 6'b111111;
    for (int t = 0; t < 7; t++) begin
      exp_g = 6'b000001 << (t % 6);
      step();
      tests++;
      if (gnt !== exp_g || out_data !== 4'((t % 6) + 1)) begin
        fails++;
        $display("FAIL rr_grant t=%0d: gnt=%b data=%0d, required %b/%0d", t, gnt, out_data, exp_g, (t % 6) + 1);
      end
      if (t < 6) begin
        for (int j = 0; j < 4; j++) begin
          tests++;
          if (ack !== exp_g) begin
            fails++;
            $display("FAIL rr_ack t=%0d beat=%0d: ack=%b, required %b", t, j, ack, exp_g);
          end
          step();
        end
        tests++;
        if (gnt !== 6'b0) begin
          fails++;
          $display("FAIL rr_bubble t=%0d: gnt=%b, required 000000", t, gnt);
        end
      end
    end
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_early_release();
    do_reset();
    req = 6'b001000;
    step();
    tests++;
    if (gnt !== 6'b001000) begin
      fails++;
      $display("FAIL early_grant: gnt=%b, required 001000", gnt);
    end
    for (int j = 0; j < 2; j++) begin
      tests++;
      if (ack !== 6'b001000) begin
        fails++;
        $display("FAIL early_ack beat=%0d: ack=%b, required 001000", j, ack);
      end
      step();
    end
    req = 6'b000011;
    #1;
    tests++;
    if (out_valid !== 1'b0 || ack !== 6'b0) begin
      fails++;
      $display("FAIL early_drop: ov=%b ack=%b, required 0/000000", out_valid, ack);
    end
    step();
    tests++;
    if (gnt !== 6'b0) begin
      fails++;
      $display("FAIL early_bubble: gnt=%b, required 000000", gnt);
    end
    step();
    tests++;
    if (gnt !== 6'b000001) begin
      fails++;
      $display("FAIL early_next_wrap: gnt=%b, required 000001", gnt);
    end
    $display("[TB] test_early_release done");
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 6'b000010;
    out_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (gnt !== 6'b000010 || out_data !== 4'd2 || ack !== 6'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_stall c=%0d: gnt=%b data=%0d ack=%b ov=%b, required 000010/2/000000/1", c, gnt, out_data, ack, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      tests++;
      if (ack !== 6'b000010) begin
        fails++;
        $display("FAIL bp_ack beat=%0d: ack=%b, required 000010", j, ack);
      end
      step();
    end
    tests++;
    if (gnt !== 6'b0) begin
      fails++;
      $display("FAIL bp_release: gnt=%b, required 000000", gnt);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 6'b000100;
    step();
    tests++;
    if (gnt !== 6'b000100) begin
      fails++;
      $display("FAIL mr_pre_grant: gnt=%b, required 000100", gnt);
    end
    req = 6'b010000;
    step();
    step();
    tests++;
    if (gnt !== 6'b010000) begin
      fails++;
      $display("FAIL mr_grant4: gnt=%b, required 010000", gnt);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (ack !== 6'b010000) begin
      fails++;
      $display("FAIL mr_ack_in_rst: ack=%b, required 010000", ack);
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (gnt !== 6'b0 || ack !== 6'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mr_after_rst: gnt=%b ack=%b ov=%b, required 0/0/0", gnt, ack, out_valid);
    end
    req = 6'b110001;
    step();
    tests++;
    if (gnt !== 6'b000001) begin
      fails++;
      $display("FAIL mr_ptr_cleared: gnt=%b, required 000001", gnt);
    end
    $display("[TB] test_mid_reset done");
  endtask

  task automatic test_maxburst1();
    do_reset();
    req = 6'b000011;
    step();
    tests++;
    if (gnt1 !== 6'b000001 || ack1 !== 6'b000001) begin
      fails++;
      $display("FAIL mb1_first: gnt=%b ack=%b, required 000001/000001", gnt1, ack1);
    end
    step();
    tests++;
    if (gnt1 !== 6'b0) begin
      fails++;
      $display("FAIL mb1_bubble: gnt=%b, required 000000", gnt1);
    end
    step();
    tests++;
    if (gnt1 !== 6'b000010 || ack1 !== 6'b000010 || out_data1 !== 4'd2) begin
      fails++;
      $display("FAIL mb1_second: gnt=%b ack=%b data=%0d, required 000010/000010/2", gnt1, ack1, out_data1);
    end
    $display("[TB] test_maxburst1 done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req = 6'b0;
    out_ready = 1'b1;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4; d4 = 4'd5; d5 = 4'd6;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_mid_reset();
    test_maxburst1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
